// File: rtl/hc32_tester.sv
// rtl/hc32_tester.sv - exhaustive functional tester for a quad 2-input OR device
//
// Purpose:
//   Walks all 256 {A,B} input combinations into an external quad OR gate,
//   waits SETTLE_CYC cycles per vector, then compares the returned outputs
//   against A|B. Mismatching vectors are counted and failing gates are
//   accumulated in a sticky mask.
//
// Parameters:
//   SETTLE_CYC  wait cycles between driving a vector and sampling Y_IN (0..15)
//
// Ports:
//   CLK        in   sole clock, rising edge
//   RST        in   asynchronous active-high reset
//   START      in   begin a full test (honoured only in IDLE or DONE)
//   Y_IN[3:0]  in   gate outputs returned from the device
//   A_OUT[3:0] out  A stimulus (vector bits 7:4)
//   B_OUT[3:0] out  B stimulus (vector bits 3:0)
//   BUSY       out  high while a test is in progress
//   DONE       out  high once the test has finished
//   PASS       out  high in DONE when no vector mismatched
//   ERR_CNT    out  number of mismatching vectors (0..256)
//   FAIL_GATE  out  sticky per-gate mismatch mask
//
// Configuration:
//   HC32_TESTER_STOP_ON_FAIL_EN  when defined, the first mismatching vector
//                                ends the test with the failing vector held.

module hc32_tester #(
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic [3:0] Y_IN,
  output logic [3:0] A_OUT,
  output logic [3:0] B_OUT,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [8:0] ERR_CNT,
  output logic [3:0] FAIL_GATE
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  // Terminal value of the settle counter; unused when SETTLE_CYC is 0.
  localparam logic [3:0] SETTLE_LAST = (SETTLE_CYC == 0) ? 4'd0 : 4'(SETTLE_CYC - 1);

  state_t     state;
  logic [7:0] vec;
  logic [3:0] settle_cnt;

  logic [3:0] expect_y;
  logic [3:0] mism;
  logic [8:0] err_next;
  logic       last_vec;
  logic       stop;

  // The stimulus pins come straight from the vector register. IDLE is only
  // reachable through reset, which clears the vector, so the pins read 0
  // there; in DONE the vector is left untouched and the last one is held.
  assign A_OUT = vec[7:4];
  assign B_OUT = vec[3:0];

  always_comb begin
    expect_y = vec[7:4] | vec[3:0];
    mism     = Y_IN ^ expect_y;
    err_next = ERR_CNT;
    // One increment per failing vector regardless of how many gates failed.
    if ((mism != 4'd0) && (ERR_CNT != 9'd256)) begin
      err_next = ERR_CNT + 9'd1;
    end
    last_vec = (vec == 8'hFF);
`ifdef HC32_TESTER_STOP_ON_FAIL_EN
    stop = last_vec || (mism != 4'd0);
`else
    stop = last_vec;
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= S_IDLE;
      vec        <= 8'd0;
      settle_cnt <= 4'd0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      PASS       <= 1'b0;
      ERR_CNT    <= 9'd0;
      FAIL_GATE  <= 4'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (START) begin
            state     <= S_DRIVE;
            vec       <= 8'd0;
            ERR_CNT   <= 9'd0;
            FAIL_GATE <= 4'd0;
            BUSY      <= 1'b1;
            DONE      <= 1'b0;
            PASS      <= 1'b0;
          end
        end

        S_DRIVE: begin
          settle_cnt <= 4'd0;
          if (SETTLE_CYC == 0) begin
            state <= S_CHECK;
          end else begin
            state <= S_SETTLE;
          end
        end

        S_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= S_CHECK;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end

        S_CHECK: begin
          ERR_CNT   <= err_next;
          FAIL_GATE <= FAIL_GATE | mism;
          if (stop) begin
            // Vector is not advanced so the final (or failing) pattern stays on the pins.
            state <= S_DONE;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            PASS  <= (err_next == 9'd0);
          end else begin
            state <= S_DRIVE;
            vec   <= vec + 8'd1;
          end
        end

        default: begin
          state <= S_IDLE;
          BUSY  <= 1'b0;
          DONE  <= 1'b0;
          PASS  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hc32_tester.sv
// tb/tb_hc32_tester.sv - scoreboard bench for hc32_tester with three settle configurations

module tb_hc32_tester;

  localparam int NI = 3;

`ifdef HC32_TESTER_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       RST;
  logic       start     [NI];
  logic [3:0] y_in      [NI];
  logic [3:0] a_out     [NI];
  logic [3:0] b_out     [NI];
  logic       busy      [NI];
  logic       done      [NI];
  logic       pass      [NI];
  logic [8:0] err_cnt   [NI];
  logic [3:0] fail_gate [NI];
  logic [3:0] stuck0;
  logic [3:0] stuck1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned S = (g == 0) ? 2 : ((g == 1) ? 0 : 15);
    assign y_in[g] = ((a_out[g] | b_out[g]) & ~stuck0) | stuck1;
    hc32_tester #(.SETTLE_CYC(S)) u_dut (
      .CLK       (CLK),
      .RST       (RST),
      .START     (start[g]),
      .Y_IN      (y_in[g]),
      .A_OUT     (a_out[g]),
      .B_OUT     (b_out[g]),
      .BUSY      (busy[g]),
      .DONE      (done[g]),
      .PASS      (pass[g]),
      .ERR_CNT   (err_cnt[g]),
      .FAIL_GATE (fail_gate[g])
    );
  end

  typedef struct {
    int inst;
    int err;
    int fg;
    int ps;
    int a;
    int b;
    int cycles;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per DONE rising edge and measures run length.
  int   cyc = 0;
  int   start_cyc [NI];
  logic busy_d    [NI];
  logic done_d    [NI];

  initial begin
    exp_t e;
    for (int i = 0; i < NI; i++) begin
      start_cyc[i] = 0;
      busy_d[i]    = 1'b0;
      done_d[i]    = 1'b0;
    end
    forever begin
      @(negedge CLK);
      cyc++;
      for (int i = 0; i < NI; i++) begin
        if (busy[i] === 1'b1 && busy_d[i] !== 1'b1) start_cyc[i] = cyc;
        if (done[i] === 1'b1 && done_d[i] !== 1'b1) begin
          check($sformatf("sb_entry_avail_u%0d", i), int'(sb_q.size() > 0), 1);
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check($sformatf("sb_inst_u%0d", i), i, e.inst);
            check($sformatf("err_cnt_u%0d", i), int'(err_cnt[i]), e.err);
            check($sformatf("fail_gate_u%0d", i), int'(fail_gate[i]), e.fg);
            check($sformatf("pass_u%0d", i), int'(pass[i]), e.ps);
            check($sformatf("a_out_u%0d", i), int'(a_out[i]), e.a);
            check($sformatf("b_out_u%0d", i), int'(b_out[i]), e.b);
            check($sformatf("cycles_u%0d", i), cyc - start_cyc[i], e.cycles);
            check($sformatf("busy_at_done_u%0d", i), int'(busy[i]), 0);
          end
        end
        busy_d[i] = busy[i];
        done_d[i] = done[i];
      end
    end
  end

  task automatic push_exp(int i, int err, int fg, int ps, int a, int b, int cycles);
    exp_t e;
    e.inst = i; e.err = err; e.fg = fg; e.ps = ps; e.a = a; e.b = b; e.cycles = cycles;
    sb_q.push_back(e);
  endtask

  task automatic pulse_start(int i);
    @(posedge CLK); #1 start[i] = 1'b1;
    @(posedge CLK); #1 start[i] = 1'b0;
  endtask

  task automatic wait_done(int i, int budget);
    logic prev;
    bit   hit;
    prev = done[i];
    hit  = 1'b0;
    for (int n = 0; n < budget && !hit; n++) begin
      @(negedge CLK);
      if (done[i] === 1'b1 && prev !== 1'b1) hit = 1'b1;
      prev = done[i];
    end
    check($sformatf("done_within_budget_u%0d", i), int'(hit), 1);
  endtask

  task automatic run(int i, int err, int fg, int ps, int a, int b, int cycles);
    push_exp(i, err, fg, ps, a, b, cycles);
    pulse_start(i);
    wait_done(i, cycles + 64);
  endtask

  task automatic check_idle(int i, string tag);
    check($sformatf("%s_a_u%0d", tag, i), int'(a_out[i]), 0);
    check($sformatf("%s_b_u%0d", tag, i), int'(b_out[i]), 0);
    check($sformatf("%s_busy_u%0d", tag, i), int'(busy[i]), 0);
    check($sformatf("%s_done_u%0d", tag, i), int'(done[i]), 0);
    check($sformatf("%s_pass_u%0d", tag, i), int'(pass[i]), 0);
    check($sformatf("%s_err_u%0d", tag, i), int'(err_cnt[i]), 0);
    check($sformatf("%s_fg_u%0d", tag, i), int'(fail_gate[i]), 0);
  endtask

  initial begin
    bit hit;
    RST    = 1'b1;
    stuck0 = 4'd0;
    stuck1 = 4'd0;
    for (int i = 0; i < NI; i++) start[i] = 1'b0;

    // Reset state and idle hold after reset release.
    repeat (3) @(posedge CLK);
    #1;
    for (int i = 0; i < NI; i++) check_idle(i, "reset");
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    for (int i = 0; i < NI; i++) check_idle(i, "post_reset");

    // Ideal device, each settle configuration: 256*(S+2) cycles.
    run(0, 0, 0, 1, 15, 15, 1024);
    run(1, 0, 0, 1, 15, 15, 512);
    run(2, 0, 0, 1, 15, 15, 4352);

    // Y[2] stuck at 0: fails whenever a[2]|b[2] (192 vectors); first is A=0,B=4.
    stuck0 = 4'b0100;
    run(0, STOP ? 1 : 192, 4, 0, STOP ? 0 : 15, STOP ? 4 : 15, STOP ? 20 : 1024);

    // Y[0] stuck at 1: fails whenever a[0]|b[0]==0 (64 vectors); first is vector 0.
    stuck0 = 4'b0000;
    stuck1 = 4'b0001;
    run(1, STOP ? 1 : 64, 1, 0, STOP ? 0 : 15, STOP ? 0 : 15, STOP ? 2 : 512);

    // Y[3] stuck 0 plus Y[1] stuck 1: 192 and 64 failing vectors overlap in 48,
    // so 208 distinct failing vectors. Vector 0 only trips gate 1.
    stuck0 = 4'b1000;
    stuck1 = 4'b0010;
    run(1, STOP ? 1 : 208, STOP ? 2 : 10, 0, STOP ? 0 : 15, STOP ? 0 : 15, STOP ? 2 : 512);
    stuck0 = 4'd0;
    stuck1 = 4'd0;

    // Asynchronous reset in the middle of vector 100 (A=6, B=4).
    pulse_start(0);
    hit = 1'b0;
    for (int n = 0; n < 1000 && !hit; n++) begin
      @(negedge CLK);
      if (a_out[0] === 4'h6 && b_out[0] === 4'h4) hit = 1'b1;
    end
    check("reach_vec100_u0", int'(hit), 1);
    #2 RST = 1'b1;
    #1;
    check_idle(0, "midrun_reset");
    @(posedge CLK); #1 RST = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    check_idle(0, "midrun_post");
    run(0, 0, 0, 1, 15, 15, 1024);

    // START held through a faulty run: no restart while busy, and the
    // following run starts the cycle after DONE with counters cleared.
    stuck0 = 4'b0100;
    push_exp(0, STOP ? 1 : 192, 4, 0, STOP ? 0 : 15, STOP ? 4 : 15, STOP ? 20 : 1024);
    push_exp(0, 0, 0, 1, 15, 15, 1024);
    @(posedge CLK); #1 start[0] = 1'b1;
    wait_done(0, 1200);
    @(negedge CLK);
    check("restart_busy_u0", int'(busy[0]), 1);
    check("restart_done_u0", int'(done[0]), 0);
    check("restart_pass_u0", int'(pass[0]), 0);
    check("restart_err_u0", int'(err_cnt[0]), 0);
    check("restart_fg_u0", int'(fail_gate[0]), 0);
    start[0] = 1'b0;
    stuck0   = 4'd0;
    wait_done(0, 1200);

    repeat (5) @(negedge CLK);
    check("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hc32_tester.md
HC32_TESTER -- requirements
Module: hc32_tester

Interface
REQ-001 Parameter: SETTLE_CYC, default 2, number of wait cycles between driving a vector and sampling Y_IN; legal range 0..15.
REQ-002 Port: CLK  input  1  sole clock; all state updates on the rising edge.
REQ-003 Port: RST  input  1  asynchronous, active-high reset.
REQ-004 Port: START  input  1  begin a full test; sampled only in IDLE or DONE.
REQ-005 Port: Y_IN  input  4  the four gate outputs returned from the quad 2-input OR device under test.
REQ-006 Port: A_OUT  output  4  registered A stimulus to the device under test.
REQ-007 Port: B_OUT  output  4  registered B stimulus to the device under test.
REQ-008 Port: BUSY  output  1  high in DRIVE, SETTLE and CHECK.
REQ-009 Port: DONE  output  1  high in DONE state.
REQ-010 Port: PASS  output  1  high in DONE when ERR_CNT == 0.
REQ-011 Port: ERR_CNT  output  9  count of mismatching vectors, 0..256.
REQ-012 Port: FAIL_GATE  output  4  sticky per-gate mask; bit i set when Y_IN[i] mismatched in any check.

Function
REQ-013 The FSM SHALL have states IDLE, DRIVE, SETTLE, CHECK and DONE.
REQ-014 The 8-bit vector counter VEC SHALL drive {A_OUT,B_OUT} = VEC, with A_OUT = VEC[7:4] and B_OUT = VEC[3:0], in DRIVE, SETTLE and CHECK; A_OUT/B_OUT SHALL be 0 in IDLE and hold the last vector in DONE.
REQ-015 IDLE or DONE with START=1 SHALL clear VEC, ERR_CNT and FAIL_GATE, and go to DRIVE next cycle.
REQ-016 DRIVE SHALL last 1 cycle, then go to SETTLE; if SETTLE_CYC == 0 it SHALL go directly to CHECK.
REQ-017 SETTLE SHALL last exactly SETTLE_CYC cycles, then go to CHECK.
REQ-018 CHECK SHALL last 1 cycle and compare Y_IN against A_OUT | B_OUT bitwise.
REQ-019 On any mismatch, CHECK SHALL increment ERR_CNT by 1 once per vector and OR the mismatch mask into FAIL_GATE.
REQ-020 CHECK with VEC != 255 SHALL increment VEC and go to DRIVE; CHECK with VEC == 255 SHALL go to DONE with no VEC wrap.
REQ-021 A full run SHALL take 256*(SETTLE_CYC+2) cycles from the first DRIVE cycle to DONE (1024 cycles at default).
REQ-022 START while BUSY SHALL be ignored.
REQ-023 ERR_CNT SHALL saturate at 256; 9 bits are sufficient, so no overflow is possible.
REQ-024 PASS SHALL be 0 outside DONE.

Reset
REQ-025 RST=1 SHALL, asynchronously and at any time including mid-test, force IDLE, VEC=0, A_OUT=0, B_OUT=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0 and FAIL_GATE=0.
REQ-026 After RST deasserts, the block SHALL remain in IDLE until START=1 is sampled.

Configuration
REQ-027 Macro HC32_TESTER_STOP_ON_FAIL_EN, when defined, SHALL make the first mismatching CHECK go directly to DONE, with PASS=0, ERR_CNT=1, and A_OUT/B_OUT holding the failing vector.
REQ-028 When HC32_TESTER_STOP_ON_FAIL_EN is undefined, all 256 vectors SHALL always be checked, per REQ-020.

Verification
REQ-029 Ideal model Y_IN = A_OUT|B_OUT, START pulse, default SETTLE_CYC -> DONE=1 after 1024 cycles, PASS=1, ERR_CNT=0, FAIL_GATE=0.
REQ-030 Model with Y_IN[2] stuck at 0 -> ERR_CNT=192, FAIL_GATE=4'b0100, PASS=0 (macro undefined).
REQ-031 Same stuck-at fault with HC32_TESTER_STOP_ON_FAIL_EN defined -> DONE at first failing vector A_OUT=4'h0, B_OUT=4'h4, ERR_CNT=1.
REQ-032 SETTLE_CYC=0 with ideal model -> DONE after 512 cycles, PASS=1; SETTLE_CYC=15 -> DONE after 4352 cycles.
REQ-033 RST pulsed at vector 100, then START -> all outputs return to 0 immediately, then a fresh run from VEC=0 completes with PASS=1.
REQ-034 START held high throughout a run -> no restart while BUSY; a new run begins the cycle after DONE, with ERR_CNT and FAIL_GATE cleared.
